// File: rtl/usb_tx_arbiter_pkg.sv
// Shared definitions for the USB transmit arbiter: handshake PIDs, grant
// encodings, FSM state type and the handshake byte builder.
package usb_tx_arbiter_pkg;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_HSK  = 2'd1;
    localparam logic [1:0] GRANT_CTL  = 2'd2;
    localparam logic [1:0] GRANT_BLK  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HSK,
        ST_CTL,
        ST_BLK,
        ST_GAP
    } arb_state_t;

    // A USB PID byte carries the complemented PID in its upper nibble.
    function automatic logic [7:0] hsk_pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_arbiter.sv
// Packet-granular arbiter sharing the ULPI transmit stream between the
// handshake generator, EP0 and bulk IN, with a fixed inter-packet gap.
module usb_tx_arbiter
    import usb_tx_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int GAP_BITS   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hsk_tvalid_i,
    output logic       hsk_tready_o,
    input  logic [3:0] hsk_tdata_i,
    input  logic       ctl_tvalid_i,
    output logic       ctl_tready_o,
    input  logic       ctl_tlast_i,
    input  logic [7:0] ctl_tdata_i,
    input  logic       blk_tvalid_i,
    output logic       blk_tready_o,
    input  logic       blk_tlast_i,
    input  logic [7:0] blk_tdata_i,
    output logic       m_tvalid_o,
    input  logic       m_tready_i,
    output logic       m_tlast_o,
    output logic [7:0] m_tdata_o,
    output logic [1:0] grant_o,
    output logic       busy_o
);

    localparam logic [GAP_BITS-1:0] GAP_LOAD =
        GAP_BITS'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    arb_state_t          state_reg, state_next;
    logic [GAP_BITS-1:0] gap_cnt_reg, gap_cnt_next;
    logic                rr_reg, rr_next;   // 0: ctl wins a data tie, 1: blk
    logic                pkt_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            gap_cnt_reg <= '0;
            rr_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            rr_reg      <= rr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        rr_next      = rr_reg;
        pkt_done     = 1'b0;
        hsk_tready_o = 1'b0;
        ctl_tready_o = 1'b0;
        blk_tready_o = 1'b0;
        m_tvalid_o   = 1'b0;
        m_tlast_o    = 1'b0;
        m_tdata_o    = 8'h00;
        grant_o      = GRANT_NONE;
        busy_o       = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (hsk_tvalid_i)
                    state_next = ST_HSK;
                else if (ctl_tvalid_i && (!blk_tvalid_i || !rr_reg))
                    state_next = ST_CTL;
                else if (blk_tvalid_i)
                    state_next = ST_BLK;
            end
            ST_HSK: begin
                m_tvalid_o   = 1'b1;
                m_tlast_o    = 1'b1;
                m_tdata_o    = hsk_pid_byte(hsk_tdata_i);
                hsk_tready_o = m_tready_i;
                grant_o      = GRANT_HSK;
                pkt_done     = m_tready_i;
            end
            ST_CTL: begin
                m_tvalid_o   = ctl_tvalid_i;
                m_tlast_o    = ctl_tlast_i;
                m_tdata_o    = ctl_tdata_i;
                ctl_tready_o = m_tready_i;
                grant_o      = GRANT_CTL;
                if (ctl_tvalid_i && m_tready_i && ctl_tlast_i) begin
                    pkt_done = 1'b1;
                    rr_next  = 1'b1;
                end
            end
            ST_BLK: begin
                m_tvalid_o   = blk_tvalid_i;
                m_tlast_o    = blk_tlast_i;
                m_tdata_o    = blk_tdata_i;
                blk_tready_o = m_tready_i;
                grant_o      = GRANT_BLK;
                if (blk_tvalid_i && m_tready_i && blk_tlast_i) begin
                    pkt_done = 1'b1;
                    rr_next  = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0)
                    state_next = ST_IDLE;
                else
                    gap_cnt_next = gap_cnt_reg - GAP_BITS'(1);
            end
            default: state_next = ST_IDLE;
        endcase

        if (pkt_done) begin
            if (GAP_CYCLES == 0) begin
                state_next = ST_IDLE;
            end else begin
                state_next   = ST_GAP;
                gap_cnt_next = GAP_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: reset, handshake framing, round-robin,
// back-pressure, handshake priority after a data packet and mid-packet reset.
module tb_usb_tx_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       hsk_tvalid_i = 1'b1;
    logic       hsk_tready_o;
    logic [3:0] hsk_tdata_i = 4'h2;
    logic       ctl_tvalid_i = 1'b1;
    logic       ctl_tready_o;
    logic       ctl_tlast_i = 1'b0;
    logic [7:0] ctl_tdata_i = 8'h10;
    logic       blk_tvalid_i = 1'b1;
    logic       blk_tready_o;
    logic       blk_tlast_i = 1'b0;
    logic [7:0] blk_tdata_i = 8'h90;
    logic       m_tvalid_o;
    logic       m_tready_i = 1'b1;
    logic       m_tlast_o;
    logic [7:0] m_tdata_o;
    logic [1:0] grant_o;
    logic       busy_o;

    int passed = 0;
    int total  = 0;

    usb_tx_arbiter #(.GAP_CYCLES(2), .GAP_BITS(4)) dut (
        .clock(clock), .reset(reset),
        .hsk_tvalid_i(hsk_tvalid_i), .hsk_tready_o(hsk_tready_o), .hsk_tdata_i(hsk_tdata_i),
        .ctl_tvalid_i(ctl_tvalid_i), .ctl_tready_o(ctl_tready_o),
        .ctl_tlast_i(ctl_tlast_i), .ctl_tdata_i(ctl_tdata_i),
        .blk_tvalid_i(blk_tvalid_i), .blk_tready_o(blk_tready_o),
        .blk_tlast_i(blk_tlast_i), .blk_tdata_i(blk_tdata_i),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .m_tlast_o(m_tlast_o), .m_tdata_o(m_tdata_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Stream stability: a stalled beat must be presented again unchanged.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    always @(negedge clock) begin
        if (prev_stall && !reset) begin
            check("flow_valid", {7'd0, m_tvalid_o}, 8'd1);
            check("flow_data", m_tdata_o, prev_data);
            check("flow_last", {7'd0, m_tlast_o}, {7'd0, prev_last});
        end
        prev_stall = m_tvalid_o && !m_tready_i && !reset;
        prev_data  = m_tdata_o;
        prev_last  = m_tlast_o;
    end

    initial begin
        int ctl_pkt, ctl_beat, blk_pkt, blk_beat, beats, stall, k, b, p;
        logic [7:0] exp_byte;
        logic [1:0] exp_grant;

        // Reset with every source requesting.
        tick(); tick();
        check("rst_grant", {6'd0, grant_o}, 8'd0);
        check("rst_busy", {7'd0, busy_o}, 8'd0);
        check("rst_mvalid", {7'd0, m_tvalid_o}, 8'd0);
        check("rst_treadys", {5'd0, hsk_tready_o, ctl_tready_o, blk_tready_o}, 8'd0);
        check("rst_mdata", m_tdata_o, 8'h00);
        reset = 1'b0;
        #1;
        check("idle_grant", {6'd0, grant_o}, 8'd0);
        check("idle_mvalid", {7'd0, m_tvalid_o}, 8'd0);
        tick();
        ctl_tvalid_i = 1'b0;
        blk_tvalid_i = 1'b0;
        #1;
        check("hsk_grant", {6'd0, grant_o}, 8'd1);
        check("hsk_data", m_tdata_o, 8'hD2);
        check("hsk_last", {7'd0, m_tlast_o}, 8'd1);
        check("hsk_valid", {7'd0, m_tvalid_o}, 8'd1);
        check("hsk_ready", {7'd0, hsk_tready_o}, 8'd1);
        tick();
        hsk_tvalid_i = 1'b0;
        #1;
        check("gap1_valid", {7'd0, m_tvalid_o}, 8'd0);
        check("gap1_busy", {7'd0, busy_o}, 8'd1);
        tick();
        check("gap2_valid", {7'd0, m_tvalid_o}, 8'd0);
        check("gap2_busy", {7'd0, busy_o}, 8'd1);
        tick();
        check("gap_end_busy", {7'd0, busy_o}, 8'd0);

        // Round-robin ctl/blk, 4 x 3-byte packets each, with a 5-cycle stall.
        ctl_pkt = 0; ctl_beat = 0; blk_pkt = 0; blk_beat = 0; beats = 0; stall = 0;
        for (int c = 0; c < 300 && beats < 24; c++) begin
            ctl_tvalid_i = (ctl_pkt < 4);
            ctl_tdata_i  = {4'h1, 2'(ctl_pkt), 2'(ctl_beat)};
            ctl_tlast_i  = (ctl_beat == 2);
            blk_tvalid_i = (blk_pkt < 4);
            blk_tdata_i  = {4'h9, 2'(blk_pkt), 2'(blk_beat)};
            blk_tlast_i  = (blk_beat == 2);
            m_tready_i   = !(beats == 4 && stall < 5);
            #1;
            if (!m_tready_i) stall++;
            if (m_tvalid_o && m_tready_i) begin
                k = beats / 3;
                b = beats % 3;
                p = k / 2;
                exp_byte  = (k % 2 == 0) ? {4'h1, 2'(p), 2'(b)} : {4'h9, 2'(p), 2'(b)};
                exp_grant = (k % 2 == 0) ? 2'd2 : 2'd3;
                check("rr_grant", {6'd0, grant_o}, {6'd0, exp_grant});
                check("rr_data", m_tdata_o, exp_byte);
                check("rr_last", {7'd0, m_tlast_o}, {7'd0, b == 2});
                beats++;
                if (ctl_tvalid_i && ctl_tready_o) begin
                    if (ctl_beat == 2) begin ctl_beat = 0; ctl_pkt++; end
                    else ctl_beat++;
                end
                if (blk_tvalid_i && blk_tready_o) begin
                    if (blk_beat == 2) begin blk_beat = 0; blk_pkt++; end
                    else blk_beat++;
                end
            end
            tick();
        end
        check("rr_beats", 8'(beats), 8'd24);
        check("rr_stalls", 8'(stall), 8'd5);
        ctl_tvalid_i = 1'b0;
        blk_tvalid_i = 1'b0;
        m_tready_i   = 1'b1;
        tick(); tick();
        check("rr_idle_busy", {7'd0, busy_o}, 8'd0);

        // Handshake request arrives mid bulk packet.
        blk_tvalid_i = 1'b1; blk_tdata_i = 8'hB0; blk_tlast_i = 1'b0;
        #1;
        check("mid_idle_grant", {6'd0, grant_o}, 8'd0);
        tick();
        check("mid_b0_grant", {6'd0, grant_o}, 8'd3);
        check("mid_b0_data", m_tdata_o, 8'hB0);
        check("mid_b0_ready", {7'd0, blk_tready_o}, 8'd1);
        tick();
        blk_tdata_i = 8'hB1; hsk_tvalid_i = 1'b1; hsk_tdata_i = 4'hA;
        #1;
        check("mid_b1_grant", {6'd0, grant_o}, 8'd3);
        check("mid_b1_data", m_tdata_o, 8'hB1);
        check("mid_b1_hskrdy", {7'd0, hsk_tready_o}, 8'd0);
        tick();
        blk_tdata_i = 8'hB2; blk_tlast_i = 1'b1;
        #1;
        check("mid_b2_data", m_tdata_o, 8'hB2);
        check("mid_b2_last", {7'd0, m_tlast_o}, 8'd1);
        tick();
        blk_tvalid_i = 1'b0; blk_tlast_i = 1'b0;
        #1;
        check("mid_gap1_valid", {7'd0, m_tvalid_o}, 8'd0);
        check("mid_gap1_grant", {6'd0, grant_o}, 8'd0);
        tick();
        check("mid_gap2_valid", {7'd0, m_tvalid_o}, 8'd0);
        tick();
        check("mid_idle_busy", {7'd0, busy_o}, 8'd0);
        tick();
        check("mid_hsk_grant", {6'd0, grant_o}, 8'd1);
        check("mid_hsk_data", m_tdata_o, 8'h5A);
        tick();
        hsk_tvalid_i = 1'b0;
        tick(); tick();

        // Reset in the middle of a ctl packet, round-robin pointer cleared.
        ctl_tvalid_i = 1'b1; ctl_tdata_i = 8'h2D; ctl_tlast_i = 1'b1;
        #1;
        check("r_idle_grant", {6'd0, grant_o}, 8'd0);
        tick();
        check("r_c1_grant", {6'd0, grant_o}, 8'd2);
        check("r_c1_data", m_tdata_o, 8'h2D);
        check("r_c1_ready", {7'd0, ctl_tready_o}, 8'd1);
        tick();
        ctl_tdata_i = 8'hC3; ctl_tlast_i = 1'b0;
        #1;
        check("r_gap_valid", {7'd0, m_tvalid_o}, 8'd0);
        check("r_gap_ready", {7'd0, ctl_tready_o}, 8'd0);
        tick(); tick();
        check("r_idle2_grant", {6'd0, grant_o}, 8'd0);
        tick();
        check("r_c2_data", m_tdata_o, 8'hC3);
        tick();
        ctl_tdata_i = 8'h11; reset = 1'b1;
        #1;
        check("r_pre_grant", {6'd0, grant_o}, 8'd2);
        tick();
        check("r_post_grant", {6'd0, grant_o}, 8'd0);
        check("r_post_valid", {7'd0, m_tvalid_o}, 8'd0);
        check("r_post_last", {7'd0, m_tlast_o}, 8'd0);
        check("r_post_busy", {7'd0, busy_o}, 8'd0);
        reset = 1'b0;
        ctl_tdata_i = 8'h77; ctl_tlast_i = 1'b1;
        blk_tvalid_i = 1'b1; blk_tdata_i = 8'h88; blk_tlast_i = 1'b1;
        tick();
        check("r_tie_grant", {6'd0, grant_o}, 8'd2);
        check("r_tie_data", m_tdata_o, 8'h77);
        tick();
        ctl_tvalid_i = 1'b0;
        tick(); tick(); tick();
        check("r_blk_grant", {6'd0, grant_o}, 8'd3);
        check("r_blk_data", m_tdata_o, 8'h88);
        tick();
        blk_tvalid_i = 1'b0;
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
